sn2bn_counter: RTL and testbench

- Downstream stage of the stochastic-number generator.
- Consumes the per-lane stochastic bit streams and the stream-active flag (`isgen`) produced by that generator.
- Counts ones per lane over one stream window and converts each lane back to an NUM_BIT-bit binary value.
- Presents the result vector through a valid/ready handshake to the next NN layer.

---
 rtl/sn2bn_counter_pkg.sv | 28 ++
 rtl/sn2bn_counter_if.sv | 23 ++
 rtl/sn2bn_counter_lane_acc.sv | 40 ++++
 rtl/sn2bn_counter.sv | 134 +++++++++++++
 tb/tb_sn2bn_counter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sn2bn_counter_pkg.sv
// Shared definitions for the stochastic-to-binary converter.
// Contents:
//   SN_NUM_BIT / SN_DIM : default lane width and lane count
//   sn2bn_state_t       : converter FSM states
//   bn_t                : binary result type for one lane (default width)
//   sat_inc             : saturating +bit increment for a counter of width w
package sn_pkg;

  localparam int SN_NUM_BIT = 8;
  localparam int SN_DIM     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } sn2bn_state_t;

  typedef logic [SN_NUM_BIT-1:0] bn_t;

  // Adds the bit to v, holding at 2**w-1 instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic b, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    if (b && (v < max_v)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/sn2bn_counter_if.sv
// Result handshake bundle between the converter and the next NN layer.
// Signals:
//   o_bn    : per-lane binary result (count of ones)
//   o_len   : number of stream bits behind the result
//   o_valid : o_bn/o_len hold a result not yet accepted
//   i_ready : consumer accepts the result this cycle
// Modports: master = converter side, slave = consumer side.
interface sn2bn_counter_if
  import sn_pkg::*;
#(
  parameter int NUM_BIT = SN_NUM_BIT,
  parameter int DIM     = SN_DIM
);

  logic [DIM-1:0][NUM_BIT-1:0] o_bn;
  logic [NUM_BIT:0]            o_len;
  logic                        o_valid;
  logic                        i_ready;

  modport master (output o_bn, output o_len, output o_valid, input i_ready);
  modport slave  (input o_bn, input o_len, input o_valid, output i_ready);

endinterface

// File: rtl/sn2bn_counter_lane_acc.sv
// One lane's ones-counter.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : zero the counter
//   i_load         : start a new window with the current bit as the count
//   i_inc          : add the current bit, saturating at 2**NUM_BIT-1
//   i_bit          : stochastic bit of this lane
//   o_acc          : current count
//   o_acc_nxt      : count including the current bit (for same-cycle transfer)
module sn_lane_acc
  import sn_pkg::*;
#(
  parameter int NUM_BIT = SN_NUM_BIT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_inc,
  input  logic               i_bit,
  output logic [NUM_BIT-1:0] o_acc,
  output logic [NUM_BIT-1:0] o_acc_nxt
);

  logic [NUM_BIT-1:0] r_acc;
  logic [NUM_BIT-1:0] w_acc_nxt;

  assign w_acc_nxt = NUM_BIT'(sat_inc(32'(r_acc), i_bit, NUM_BIT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_acc <= '0;
    else if (i_clr)  r_acc <= '0;
    else if (i_load) r_acc <= {{(NUM_BIT-1){1'b0}}, i_bit};
    else if (i_inc)  r_acc <= w_acc_nxt;
  end

  assign o_acc     = r_acc;
  assign o_acc_nxt = w_acc_nxt;

endmodule

// File: rtl/sn2bn_counter.sv
// Stochastic-to-binary converter: counts ones per lane over one stream
// window (i_isgen high) and hands the counts to the next layer.
// Ports:
//   i_clk_sn2bn, i_rst_n_sn2bn : clock, asynchronous active-low reset
//   i_isgen                    : stream active, one valid bit per lane per cycle
//   i_sn_bit[DIM]              : stochastic bit per lane
//   i_abort                    : drop the stream in progress, clear o_overrun
//   bus (master)               : o_bn / o_len / o_valid / i_ready result handshake
//   o_busy                     : a stream is being accumulated or drained
//   o_overrun                  : sticky, an unaccepted result was overwritten
module sn2bn_counter
  import sn_pkg::*;
#(
  parameter int NUM_BIT = SN_NUM_BIT,
  parameter int DIM     = SN_DIM
) (
  input  logic           i_clk_sn2bn,
  input  logic           i_rst_n_sn2bn,
  input  logic           i_isgen,
  input  logic [DIM-1:0] i_sn_bit,
  input  logic           i_abort,
  sn2bn_counter_if.master bus,
  output logic           o_busy,
  output logic           o_overrun
);

  localparam logic [NUM_BIT:0] LEN_FULL = {1'b1, {NUM_BIT{1'b0}}};

  sn2bn_state_t r_state, w_state_nxt;
  logic [NUM_BIT:0] r_len;
  logic             w_clr, w_load, w_inc, w_xfer, w_xfer_full;

  logic [DIM-1:0][NUM_BIT-1:0] w_acc, w_acc_nxt;
  logic [DIM-1:0][NUM_BIT-1:0] r_bn;
  logic [NUM_BIT:0]            r_olen;
  logic                        r_valid, r_overrun, r_busy;

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    sn_lane_acc #(.NUM_BIT(NUM_BIT)) u_lane (
      .i_clk     (i_clk_sn2bn),
      .i_rst_n   (i_rst_n_sn2bn),
      .i_clr     (w_clr),
      .i_load    (w_load),
      .i_inc     (w_inc),
      .i_bit     (i_sn_bit[g]),
      .o_acc     (w_acc[g]),
      .o_acc_nxt (w_acc_nxt[g])
    );
  end

  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_xfer      = 1'b0;
    w_xfer_full = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_isgen) begin
          w_load      = 1'b1;
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        // Abort beats stream end; a full window still counts the current bit.
        if (i_abort) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end else if (!i_isgen) begin
          w_xfer      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_len == LEN_FULL) begin
          w_inc       = 1'b1;
          w_xfer      = 1'b1;
          w_xfer_full = 1'b1;
          w_state_nxt = DRAIN;
        end else begin
          w_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (i_abort) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end else if (!i_isgen) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Length counter stops at LEN_FULL; the window-full bit is not added to it.
  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn)             r_len <= '0;
    else if (w_clr)                 r_len <= '0;
    else if (w_load)                r_len <= {{NUM_BIT{1'b0}}, 1'b1};
    else if (w_inc && !w_xfer_full) r_len <= r_len + 1'b1;
  end

  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) begin
      r_bn      <= '0;
      r_olen    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_bn   <= w_xfer_full ? w_acc_nxt : w_acc;
        r_olen <= r_len;
      end
      if (w_xfer)                    r_valid <= 1'b1;
      else if (r_valid && bus.i_ready) r_valid <= 1'b0;
      // Abort never coincides with a transfer, so its clear cannot hide an overrun.
      if (i_abort)                                  r_overrun <= 1'b0;
      else if (w_xfer && r_valid && !bus.i_ready)   r_overrun <= 1'b1;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign bus.o_bn    = r_bn;
  assign bus.o_len   = r_olen;
  assign bus.o_valid = r_valid;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_sn2bn_counter.sv
module tb_sn2bn_counter;
  import sn_pkg::*;

  localparam int NB = 8;
  localparam int D  = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         isgen;
  logic         abort_i;
  logic [D-1:0] sn_bit;
  logic         busy;
  logic         ovr;

  sn2bn_counter_if #(.NUM_BIT(NB), .DIM(D)) bus ();

  sn2bn_counter #(.NUM_BIT(NB), .DIM(D)) dut (
    .i_clk_sn2bn   (clk),
    .i_rst_n_sn2bn (rst_n),
    .i_isgen       (isgen),
    .i_sn_bit      (sn_bit),
    .i_abort       (abort_i),
    .bus           (bus),
    .o_busy        (busy),
    .o_overrun     (ovr)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int first_c;
  int cap_bn;
  int cap_len;
  int busy_at_end;

  initial begin
    rst_n      = 1'b0;
    isgen      = 1'b0;
    abort_i    = 1'b0;
    sn_bit     = '0;
    bus.i_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check_eq("rst_valid", 32'(bus.o_valid), 0);
    check_eq("rst_bn0", 32'(bus.o_bn[0]), 0);
    check_eq("rst_len", 32'(bus.o_len), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ovr", 32'(ovr), 0);
    rst_n = 1'b1;
    tick();

    // 255 ones then a zero: 256-bit stream, no saturation
    for (int c = 1; c <= 256; c++) begin
      isgen  = 1'b1;
      sn_bit = (c <= 255) ? '1 : '0;
      tick();
    end
    check_eq("full_novalid_yet", 32'(bus.o_valid), 0);
    check_eq("full_busy", 32'(busy), 1);
    isgen  = 1'b0;
    sn_bit = '0;
    tick();
    check_eq("full_valid", 32'(bus.o_valid), 1);
    for (int i = 0; i < D; i++) check_eq($sformatf("full_bn%0d", i), 32'(bus.o_bn[i]), 255);
    check_eq("full_len", 32'(bus.o_len), 256);
    check_eq("full_ovr", 32'(ovr), 0);
    check_eq("full_busy_end", 32'(busy), 0);
    tick();
    check_eq("full_hs_clear", 32'(bus.o_valid), 0);

    // Lane 0 zeros, lane 1 alternating 1,0
    for (int c = 1; c <= 256; c++) begin
      isgen     = 1'b1;
      sn_bit    = '0;
      sn_bit[1] = (c % 2 == 1);
      tick();
    end
    isgen  = 1'b0;
    sn_bit = '0;
    tick();
    check_eq("alt_valid", 32'(bus.o_valid), 1);
    check_eq("alt_bn0", 32'(bus.o_bn[0]), 0);
    check_eq("alt_bn1", 32'(bus.o_bn[1]), 128);
    check_eq("alt_bn2", 32'(bus.o_bn[2]), 0);
    check_eq("alt_len", 32'(bus.o_len), 256);
    tick();

    // Abort at cycle 60 of an all-ones stream
    for (int c = 1; c <= 60; c++) begin
      isgen   = 1'b1;
      sn_bit  = '1;
      abort_i = (c == 60);
      tick();
      if (c == 59) check_eq("abort_busy_before", 32'(busy), 1);
    end
    check_eq("abort_busy", 32'(busy), 0);
    abort_i = 1'b0;
    isgen   = 1'b0;
    sn_bit  = '0;
    pulses  = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.o_valid) pulses++;
      tick();
    end
    check_eq("abort_no_valid", 32'(pulses), 0);
    check_eq("abort_bn1_kept", 32'(bus.o_bn[1]), 128);
    check_eq("abort_len_kept", 32'(bus.o_len), 256);

    // Overrun: two 10-cycle streams with the consumer stalled
    bus.i_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 10; c++) begin
        isgen  = 1'b1;
        sn_bit = '1;
        tick();
      end
      isgen  = 1'b0;
      sn_bit = '0;
      tick();
      check_eq($sformatf("ovr_valid_s%0d", s), 32'(bus.o_valid), 1);
      check_eq($sformatf("ovr_flag_s%0d", s), 32'(ovr), (s == 1) ? 1 : 0);
      check_eq($sformatf("ovr_bn3_s%0d", s), 32'(bus.o_bn[3]), 10);
      check_eq($sformatf("ovr_len_s%0d", s), 32'(bus.o_len), 10);
      if (s == 0) repeat (2) tick();
    end
    bus.i_ready = 1'b1;
    tick();
    check_eq("ovr_hs_clear", 32'(bus.o_valid), 0);
    check_eq("ovr_sticky", 32'(ovr), 1);
    tick();
    check_eq("ovr_sticky2", 32'(ovr), 1);

    // Abort in IDLE only clears the overrun flag
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_eq("idle_abort_ovr", 32'(ovr), 0);
    check_eq("idle_abort_busy", 32'(busy), 0);
    check_eq("idle_abort_bn3", 32'(bus.o_bn[3]), 10);

    // 300-cycle all-ones stream: one saturated result, then drain
    pulses      = 0;
    first_c     = 0;
    cap_bn      = -1;
    cap_len     = -1;
    busy_at_end = 0;
    for (int c = 1; c <= 300; c++) begin
      isgen  = 1'b1;
      sn_bit = '1;
      tick();
      if (bus.o_valid) begin
        pulses++;
        if (first_c == 0) begin
          first_c = c;
          cap_bn  = int'(bus.o_bn[5]);
          cap_len = int'(bus.o_len);
        end
      end
      if (c == 300) busy_at_end = int'(busy);
    end
    isgen  = 1'b0;
    sn_bit = '0;
    tick();
    check_eq("long_busy_drop", 32'(busy), 0);
    for (int c = 0; c < 5; c++) begin
      if (bus.o_valid) pulses++;
      tick();
    end
    check_eq("long_first_valid_cycle", 32'(first_c), 257);
    check_eq("long_single_result", 32'(pulses), 1);
    check_eq("long_bn5", 32'(cap_bn), 255);
    check_eq("long_len", 32'(cap_len), 256);
    check_eq("long_busy_during", 32'(busy_at_end), 1);
    check_eq("long_no_ovr", 32'(ovr), 0);

    // Asynchronous reset at cycle 50 of a stream
    for (int c = 1; c <= 50; c++) begin
      isgen  = 1'b1;
      sn_bit = '1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.o_valid), 0);
    check_eq("arst_bn0", 32'(bus.o_bn[0]), 0);
    check_eq("arst_len", 32'(bus.o_len), 0);
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_ovr", 32'(ovr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("arst_restart_busy", 32'(busy), 1);
    isgen  = 1'b0;
    sn_bit = '0;
    tick();
    check_eq("arst_restart_valid", 32'(bus.o_valid), 1);
    check_eq("arst_restart_bn7", 32'(bus.o_bn[7]), 5);
    check_eq("arst_restart_len", 32'(bus.o_len), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
